// File: rtl/rtc_bus_sequencer.sv
// Two-requester sequencer for the multiplexed RTC bus: round-robin arbitration,
// address then data phase with parameterised setup/strobe/hold timing.
module rtc_bus_sequencer #(
  parameter int unsigned N    = 8,
  parameter int unsigned T_SU = 2,
  parameter int unsigned T_PW = 10,
  parameter int unsigned T_HD = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_we,
  input  logic [N-1:0] req0_addr,
  input  logic [N-1:0] req0_wdata,
  input  logic         req1_valid,
  input  logic         req1_we,
  input  logic [N-1:0] req1_addr,
  input  logic [N-1:0] req1_wdata,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic [N-1:0] rdata,
  output logic         done,
  output logic         done_id,
  output logic         busy,
  output logic         AD,
  output logic         CS,
  output logic         WR,
  output logic         RD,
  inout  wire  [N-1:0] salient
);

  localparam int unsigned TMAX = (T_SU > T_PW) ? ((T_SU > T_HD) ? T_SU : T_HD)
                                               : ((T_PW > T_HD) ? T_PW : T_HD);
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, RECOV
  } state_t;

  typedef struct packed {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         id;
  } req_t;

  state_t         r_state, w_next_state;
  logic [CW-1:0]  r_cnt, w_next_cnt;
  req_t           r_req, w_req;
  logic           r_last;
  logic           r_done, r_done_id;
  logic [N-1:0]   r_rdata;

  logic           w_gnt0, w_gnt1, w_accept, w_fin, w_capture;
  logic           w_ad, w_cs, w_wr, w_rd, w_drive;
  logic [N-1:0]   w_bus;

  // Round-robin: on a tie, serve the requester that was not served last.
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last);
  assign w_gnt0     = req0_valid & ~w_gnt1;
  assign req0_ready = reset & (r_state == IDLE) & w_gnt0;
  assign req1_ready = reset & (r_state == IDLE) & w_gnt1;
  assign w_accept   = req0_ready | req1_ready;
  assign w_req      = w_gnt1 ? req_t'{req1_we, req1_addr, req1_wdata, 1'b1}
                             : req_t'{req0_we, req0_addr, req0_wdata, 1'b0};

  assign w_fin      = (r_state == RECOV) && (r_cnt == '0);
  assign w_capture  = (r_state == DATA_PW) && (r_cnt == '0) && !r_req.we;

  // State register and phase down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state: each phase holds for its count, then loads the next phase's count.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (r_state == IDLE) begin
      if (w_accept) begin
        w_next_state = ADDR_SU;
        w_next_cnt   = CW'(T_SU - 1);
      end
    end else if (r_cnt != '0) begin
      w_next_cnt = r_cnt - CW'(1);
    end else begin
      unique case (r_state)
        ADDR_SU: begin w_next_state = ADDR_PW; w_next_cnt = CW'(T_PW - 1); end
        ADDR_PW: begin w_next_state = ADDR_HD; w_next_cnt = CW'(T_HD - 1); end
        ADDR_HD: begin w_next_state = DATA_SU; w_next_cnt = CW'(T_SU - 1); end
        DATA_SU: begin w_next_state = DATA_PW; w_next_cnt = CW'(T_PW - 1); end
        DATA_PW: begin w_next_state = DATA_HD; w_next_cnt = CW'(T_HD - 1); end
        DATA_HD: begin w_next_state = RECOV;   w_next_cnt = CW'(T_HD - 1); end
        RECOV:   begin w_next_state = IDLE;    w_next_cnt = '0;            end
        default: begin w_next_state = IDLE;    w_next_cnt = '0;            end
      endcase
    end
  end

  // Pin decode from the current phase; the bus is released for the whole read data phase.
  always_comb begin
    w_ad    = 1'b1;
    w_cs    = 1'b1;
    w_wr    = 1'b1;
    w_rd    = 1'b1;
    w_drive = 1'b0;
    w_bus   = '0;
    unique case (r_state)
      ADDR_SU, ADDR_PW, ADDR_HD: begin
        w_ad    = 1'b0;
        w_cs    = 1'b0;
        w_drive = 1'b1;
        w_bus   = r_req.addr;
        w_wr    = (r_state != ADDR_PW);
      end
      DATA_SU, DATA_PW, DATA_HD: begin
        w_cs = 1'b0;
        if (r_req.we) begin
          w_drive = 1'b1;
          w_bus   = r_req.wdata;
          w_wr    = (r_state != DATA_PW);
        end else begin
          w_rd = (r_state != DATA_PW);
        end
      end
      default: ;
    endcase
  end

  assign AD      = w_ad;
  assign CS      = w_cs;
  assign WR      = w_wr;
  assign RD      = w_rd;
  assign salient = w_drive ? w_bus : {N{1'bz}};
  assign busy    = (r_state != IDLE);

  // Request latch, arbitration history, read capture and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req     <= '0;
      r_last    <= 1'b1;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_req  <= w_req;
        r_last <= w_req.id;
      end
      if (w_fin)     r_done_id <= r_req.id;
      if (w_capture) r_rdata   <= salient;
    end
  end

  assign done    = r_done;
  assign done_id = r_done_id;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default-timing instance plus a
// minimum-timing instance, each with a pulled-up bus and a read-data model.
module tb_rtc_bus_sequencer;

  logic       clk;
  logic       reset;

  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ready, req1_ready, done0, done_id0, busy0;
  logic [7:0] rdata0, model0;
  logic       AD0, CS0, WR0, RD0;
  wire  [7:0] salient0;

  logic       c_valid, c_we, z_valid, z_we;
  logic [7:0] c_addr, c_wdata, z_addr, z_wdata;
  logic       c_ready0, c_ready1, done1, done_id1, busy1;
  logic [7:0] rdata1, model1;
  logic       AD1, CS1, WR1, RD1;
  wire  [7:0] salient1;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [22:0] RST_VEC = {7'b1111000, 8'h00, 8'hFF};

  rtc_bus_sequencer #(.N(8), .T_SU(2), .T_PW(10), .T_HD(2)) u0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rdata(rdata0), .done(done0), .done_id(done_id0), .busy(busy0),
    .AD(AD0), .CS(CS0), .WR(WR0), .RD(RD0), .salient(salient0)
  );

  rtc_bus_sequencer #(.N(8), .T_SU(1), .T_PW(1), .T_HD(1)) u1 (
    .clk(clk), .reset(reset),
    .req0_valid(c_valid), .req0_we(c_we), .req0_addr(c_addr), .req0_wdata(c_wdata),
    .req1_valid(z_valid), .req1_we(z_we), .req1_addr(z_addr), .req1_wdata(z_wdata),
    .req0_ready(c_ready0), .req1_ready(c_ready1),
    .rdata(rdata1), .done(done1), .done_id(done_id1), .busy(busy1),
    .AD(AD1), .CS(CS1), .WR(WR1), .RD(RD1), .salient(salient1)
  );

  // Released bus reads as all ones; the RTC model drives only while RD is low.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (salient0[g]);
    pullup (salient1[g]);
  end
  assign salient0 = (!RD0) ? model0 : 8'hzz;
  assign salient1 = (!RD1) ? model1 : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] obs0();
    return {AD0, CS0, WR0, RD0, busy0, done0, done_id0, rdata0, salient0};
  endfunction

  function automatic logic [22:0] obs1();
    return {AD1, CS1, WR1, RD1, busy1, done1, done_id1, rdata1, salient1};
  endfunction

  // Expected pins for cycle c after the accept edge, from the published phase timeline.
  function automatic logic [22:0] exp_vec(input int c, input int su, input int pw, input int hd,
                                          input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                          input logic [7:0] rmod, input logic id, input logic pid,
                                          input logic [7:0] prd);
    int L;
    logic ad, cs, wr, rd, bsy, dn, did;
    logic [7:0] rdv, sal;
    L = su + pw + hd;
    ad = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b1; bsy = 1'b1; dn = 1'b0; did = pid;
    rdv = prd; sal = 8'hFF;
    if (c <= L) begin
      ad = 1'b0; cs = 1'b0; sal = addr;
      if (c > su && c <= su + pw) wr = 1'b0;
    end else if (c <= 2 * L) begin
      cs = 1'b0;
      if (we) sal = wdata;
      if (c > L + su && c <= L + su + pw) begin
        if (we) wr = 1'b0;
        else begin rd = 1'b0; sal = rmod; end
      end
    end else if (c > 2 * L + hd) begin
      bsy = 1'b0; dn = 1'b1; did = id;
    end
    if (!we && c > L + su + pw) rdv = rmod;
    return {ad, cs, wr, rd, bsy, dn, did, rdv, sal};
  endfunction

  task automatic chk(input string tag, input int c, input logic [22:0] obs, input logic [22:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  logic       t_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] t_ad [4] = '{8'h21, 8'h22, 8'h30, 8'h31};
  logic [7:0] t_wd [4] = '{8'h15, 8'h00, 8'h4C, 8'h00};
  logic [7:0] t_rm [4] = '{8'h37, 8'h37, 8'h37, 8'h5A};

  initial begin
    logic       pid;
    logic [7:0] prd;
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h21; req0_wdata = 8'h15;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h22; req1_wdata = 8'h00;
    model0 = 8'h37;
    c_valid = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00; model1 = 8'h00;
    z_valid = 1'b0; z_we = 1'b0; z_addr = 8'h00; z_wdata = 8'h00;

    repeat (5) @(negedge clk);
    chk("reset_pins", 0, obs0(), RST_VEC);
    chk("reset_ready", 0, 23'({req0_ready, req1_ready}), 23'd0);
    chk("reset_pins_min", 0, obs1(), RST_VEC);
    reset = 1'b1;
    #1;
    chk("release_ready", 0, 23'({req0_ready, req1_ready}), 23'd2);

    // Both requesters held valid: writes from req0 alternate with reads from req1.
    pid = 1'b0; prd = 8'h00;
    for (int t = 0; t < 4; t++) begin
      for (int c = 1; c <= 31; c++) begin
        @(negedge clk);
        chk("arb_pins", t * 100 + c, obs0(),
            exp_vec(c, 2, 10, 2, t_we[t], t_ad[t], t_wd[t], t_rm[t], 1'(t % 2), pid, prd));
        if (c < 31)
          chk("busy_ready", t * 100 + c, 23'({req0_ready, req1_ready}), 23'd0);
        else
          chk("done_ready", t * 100 + c, 23'({req0_ready, req1_ready}),
              (t == 3) ? 23'd0 : ((t % 2 == 0) ? 23'd1 : 23'd2));
        if (c == 1) begin
          model0 = t_rm[t];
          if (t == 0) begin req0_addr = 8'h30; req0_wdata = 8'h4C; end
          if (t == 1) req1_addr = 8'h31;
          if (t == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
      end
      pid = 1'(t % 2);
      if (!t_we[t]) prd = t_rm[t];
    end
    @(negedge clk);
    chk("done_pulse_end", 32, obs0(), {7'b1111001, 8'h5A, 8'hFF});

    // Write aborted by reset in its 20th cycle; a pending read then goes first.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h40; req0_wdata = 8'h66;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("abort_pins", c, obs0(), exp_vec(c, 2, 10, 2, 1'b1, 8'h40, 8'h66, 8'h00, 1'b0, 1'b1, 8'h5A));
      if (c == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h41; model0 = 8'h7E;
      end
    end
    #1 reset = 1'b0;
    #1;
    chk("abort_async", 20, obs0(), RST_VEC);
    chk("abort_ready", 20, 23'({req0_ready, req1_ready}), 23'd0);
    @(negedge clk);
    chk("abort_no_done", 21, obs0(), RST_VEC);
    reset = 1'b1;
    #1;
    chk("abort_release_ready", 21, 23'({req0_ready, req1_ready}), 23'd1);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      chk("post_reset_read", c, obs0(), exp_vec(c, 2, 10, 2, 1'b0, 8'h41, 8'h00, 8'h7E, 1'b1, 1'b0, 8'h00));
      if (c == 1) req1_valid = 1'b0;
    end

    // Minimum timing: one cycle per phase, back-to-back write then read.
    c_valid = 1'b1; c_we = 1'b1; c_addr = 8'h0A; c_wdata = 8'h0B;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("min_write", c, obs1(), exp_vec(c, 1, 1, 1, 1'b1, 8'h0A, 8'h0B, 8'h00, 1'b0, 1'b0, 8'h00));
      if (c == 1) begin c_we = 1'b0; c_addr = 8'h0C; model1 = 8'hC3; end
    end
    chk("min_done_ready", 8, 23'({c_ready0, c_ready1}), 23'd2);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("min_read", c, obs1(), exp_vec(c, 1, 1, 1, 1'b0, 8'h0C, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h00));
      if (c == 1) c_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequences read and write cycles on the multiplexed address/data RTC bus (AD, CS, WR, RD, salient) and shares that bus between two requesters: the PicoBlaze port logic and a hardware poller. It sits between the processor port registers and the RTC pins. It arbitrates round-robin, generates all strobe timing from parameterised cycle counts, and returns read data with a one-cycle completion pulse.

## Interface
- N, 8, bus / address / data width
- T_SU, 2, setup cycles before each strobe (≥1)
- T_PW, 10, strobe low width in cycles (≥1)
- T_HD, 2, hold cycles after each strobe; also the CS-high recovery length (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  transaction request, held until accepted
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  N  RTC register address
- req0_wdata / req1_wdata  in  N  write data
- req0_ready / req1_ready  out  1  combinational grant; transfer on valid&ready at a rising edge
- rdata  out  N  last read data; unchanged by writes
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester index of completed transaction
- busy  out  1  high whenever state ≠ IDLE
- AD  out  1  0 = address phase, 1 = data phase
- CS, WR, RD  out  1  active-low chip select and strobes
- salient  inout  N  multiplexed bus; high-Z when not driven

## Operation
- States: IDLE, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, RECOV. A down-counter loads (param−1) on state entry and advances the state when it reaches 0.
- IDLE: ready goes to the granted requester with valid high. If both are valid, grant the one not served last; the last-served flag resets to 1, so req0 wins first.
- On accept: latch we, addr, wdata and the requester index; go to ADDR_SU.
- ADDR_SU/PW/HD (T_SU/T_PW/T_HD cycles): AD=0, CS=0, salient=addr; WR=0 only in ADDR_PW.
- DATA_SU/PW/HD, write: AD=1, CS=0, salient=wdata; WR=0 only in DATA_PW.
- DATA_SU/PW/HD, read: AD=1, CS=0, salient high-Z; RD=0 only in DATA_PW. rdata captures salient at the edge ending the last DATA_PW cycle.
- RECOV (T_HD cycles): CS=1, AD=1, strobes high, salient high-Z.
- Return to IDLE; done=1 and done_id=latched index for that first IDLE cycle. A new accept is legal in the same cycle.
- Never WR and RD low together. Never drive salient during a read data phase.
- Requests that drop valid before accept have no effect. Requests are ignored while busy.

## Timing
- Reset values: AD=1, CS=1, WR=1, RD=1, salient high-Z, rdata=0, done=0, done_id=0, busy=0, ready=0, state IDLE.
- Reset assertion mid-transaction: all outputs return to reset values immediately (asynchronous); no done pulse; the transaction is discarded.
- Accept edge = edge 0. Defaults occupy cycles 1–30: ADDR_SU 1–2, ADDR_PW 3–12, ADDR_HD 13–14, DATA_SU 15–16, DATA_PW 17–26, DATA_HD 27–28, RECOV 29–30. done is high in cycle 31.
- General latency: accept to done = 2·(T_SU+T_PW+T_HD)+T_HD+1 cycles.
- Maximum throughput with a continuous requester: one transaction per 2·(T_SU+T_PW+T_HD)+T_HD+1 cycles.
- Bus turnaround: salient is released no later than the edge entering DATA_SU of a read and stays released through RECOV.

## Test plan
- Reset: hold reset=0 for 5 cycles with both requesters valid -> all outputs at reset values, ready=0, salient Z; first accept on the first edge after release.
- Write: req0 write addr 0x21, wdata 0x15 -> AD=0 with salient=0x21 in cycles 1–14 and WR=0 in cycles 3–12; AD=1 with salient=0x15 in cycles 15–28 and WR=0 in cycles 17–26; CS=1 in cycles 29–30; done=1, done_id=0 in cycle 31.
- Read: req1 read addr 0x22, bus model drives 0x37 while RD=0 -> salient Z from cycle 15, RD=0 in cycles 17–26, rdata=0x37 and done_id=1 in cycle 31.
- Arbitration: both requesters valid continuously -> grant order req0, req1, req0, req1; each accept falls in the previous transaction's done cycle, a 31-cycle period.
- Reset mid-op: assert reset=0 in cycle 20 of a write -> CS, WR, AD, RD high and salient Z in the same cycle; no done; after release a pending req1 is accepted first.
- Parameter corner: T_SU=T_PW=T_HD=1 -> each phase lasts 1 cycle and done arrives 8 cycles after accept.
